regbank_snapshot: RTL and testbench

REGBANK_SNAPSHOT -- requirements
Module: regbank_snapshot

---
 rtl/regbank_pkg.sv | 56 +++++
 rtl/counter_snapshot.sv | 40 ++++
 rtl/regbank_snapshot.sv | 126 ++++++++++++
 tb/tb_regbank_snapshot.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Address map constants, region decode and byte-select helpers shared by
// the regbank_snapshot register bank and its counter_snapshot sub-block.
package regbank_pkg;

    localparam logic [7:0] OSD_TOP    = 8'h7F;
    localparam logic [7:0] PAGE_ADDR  = 8'h80;
    localparam logic [7:0] CTRL_BASE  = 8'h81;
    localparam logic [7:0] CNT_BASE   = 8'hA0;
    localparam logic [7:0] PULSE_ADDR = 8'hF0;
    localparam logic [7:0] CLR_ADDR   = 8'hF1;
    localparam logic [7:0] INFO_ADDR  = 8'hF2;
    localparam logic [7:0] CLR_ALL    = 8'hFF;

    typedef enum logic [2:0] {
        RGN_OSD,
        RGN_PAGE,
        RGN_CTRL,
        RGN_CNT,
        RGN_PULSE,
        RGN_CLR,
        RGN_INFO,
        RGN_NONE
    } region_t;

    // Classify a byte address; sizes of the control and counter windows
    // come from the instantiating module's parameters.
    function automatic region_t addr_region(input logic [7:0] a,
                                            input int unsigned num_ctrl,
                                            input int unsigned num_counters);
        int unsigned ai;
        ai = 32'(a);
        if (a <= OSD_TOP)                                         return RGN_OSD;
        if (a == PAGE_ADDR)                                       return RGN_PAGE;
        if (ai >= 32'(CTRL_BASE) && ai < 32'(CTRL_BASE) + num_ctrl) return RGN_CTRL;
        if (ai >= 32'(CNT_BASE) && ai < 32'(CNT_BASE) + 4 * num_counters)
                                                                  return RGN_CNT;
        if (a == PULSE_ADDR)                                      return RGN_PULSE;
        if (a == CLR_ADDR)                                        return RGN_CLR;
        if (a == INFO_ADDR)                                       return RGN_INFO;
        return RGN_NONE;
    endfunction

    // Counter bytes are presented MSB first: byte 0 is bits [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] b);
        logic [7:0] r;
        r = w[31:24];
        case (b)
            2'd0: r = w[31:24];
            2'd1: r = w[23:16];
            2'd2: r = w[15:8];
            2'd3: r = w[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/counter_snapshot.sv
// Single-entry shadow of one 32-bit counter: captured when byte 0 of that
// counter is consumed, so bytes 1..3 read back a coherent value.
module counter_snapshot
    import regbank_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        readEn,
    input  region_t     rgn,
    input  logic [3:0]  cnt_idx,
    input  logic [1:0]  cnt_byte,
    input  logic [31:0] live_word,
    output logic        snap_hit,
    output logic [31:0] shadow_word
);

    logic [31:0] shadow;
    logic [3:0]  shadow_idx;
    logic        shadow_vld;
    logic        capture;

    assign capture     = readEn && (rgn == RGN_CNT) && (cnt_byte == 2'd0);
    assign snap_hit    = shadow_vld && (rgn == RGN_CNT) && (cnt_byte != 2'd0)
                         && (cnt_idx == shadow_idx);
    assign shadow_word = shadow;

    // Latch the whole addressed counter on a consumed byte-0 read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow     <= '0;
            shadow_idx <= '0;
            shadow_vld <= 1'b0;
        end else if (capture) begin
            shadow     <= live_word;
            shadow_idx <= cnt_idx;
            shadow_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/regbank_snapshot.sv
// I2C-facing register bank: OSD RAM write window, page offset, control
// bytes, command pulses, counter clears and read-only status counters.
// Optional feature macro: REGBANK_SNAPSHOT_EN (coherent multi-byte counter reads).
module regbank_snapshot
    import regbank_pkg::*;
#(
    parameter int unsigned               NUM_CTRL     = 4,
    parameter int unsigned               NUM_COUNTERS = 6,
    parameter int unsigned               PAGE_W       = 3,
    parameter logic [NUM_CTRL*8-1:0]     CTRL_INIT    = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [7:0]                   addr,
    input  logic [7:0]                   dataIn,
    input  logic                         writeEn,
    input  logic                         readEn,
    output logic [7:0]                   dataOut,
    output logic [PAGE_W+6:0]            ram_wraddress,
    output logic [7:0]                   ram_dataIn,
    output logic                         ram_wren,
    output logic [NUM_CTRL*8-1:0]        ctrl,
    output logic [7:0]                   pulse,
    input  logic [NUM_COUNTERS*32-1:0]   counters,
    output logic [NUM_COUNTERS-1:0]      counter_clr
);

    region_t                 rgn;
    logic [3:0]              cnt_idx;
    logic [1:0]              cnt_byte;
    logic [31:0]             live_word;
    logic [7:0]              rd_data;
    logic [NUM_COUNTERS-1:0] clr_next;
    logic [PAGE_W-1:0]       page;
    logic                    snap_hit;
    logic [31:0]             shadow_word;

    assign ram_dataIn = dataIn;

    // Address decode and selection of the live counter word under addr.
    always_comb begin
        rgn       = addr_region(addr, NUM_CTRL, NUM_COUNTERS);
        cnt_idx   = 4'((addr - CNT_BASE) >> 2);
        cnt_byte  = addr[1:0];
        live_word = '0;
        for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
            if (cnt_idx == 4'(k)) live_word = counters[k*32 +: 32];
        end
    end

`ifdef REGBANK_SNAPSHOT_EN
    counter_snapshot u_snap (
        .clk         (clk),
        .reset_n     (reset_n),
        .readEn      (readEn),
        .rgn         (rgn),
        .cnt_idx     (cnt_idx),
        .cnt_byte    (cnt_byte),
        .live_word   (live_word),
        .snap_hit    (snap_hit),
        .shadow_word (shadow_word)
    );
`else
    logic unused_read_en;
    assign unused_read_en = readEn;
    assign snap_hit       = 1'b0;
    assign shadow_word    = '0;
`endif

    // Read data mux; unmapped and write-only locations read as zero.
    always_comb begin
        rd_data = '0;
        case (rgn)
            RGN_PAGE: rd_data = 8'(page);
            RGN_CTRL: begin
                for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                    if (addr == CTRL_BASE + 8'(k)) rd_data = ctrl[k*8 +: 8];
                end
            end
            RGN_CNT:  rd_data = snap_hit ? word_byte(shadow_word, cnt_byte)
                                         : word_byte(live_word, cnt_byte);
            RGN_INFO: rd_data = {4'(NUM_COUNTERS - 1), 4'(NUM_CTRL)};
            default:  rd_data = '0;
        endcase
    end

    // Decode a clear command into per-counter request bits.
    always_comb begin
        clr_next = '0;
        if (writeEn && rgn == RGN_CLR) begin
            if (dataIn == CLR_ALL) begin
                clr_next = '1;
            end else begin
                for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                    if (dataIn == 8'(k)) clr_next[k] = 1'b1;
                end
            end
        end
    end

    // Register state, registered read data and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dataOut       <= '0;
            page          <= '0;
            ctrl          <= CTRL_INIT;
            pulse         <= '0;
            counter_clr   <= '0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
        end else begin
            dataOut     <= rd_data;
            ram_wren    <= writeEn && (rgn == RGN_OSD);
            pulse       <= (writeEn && rgn == RGN_PULSE) ? dataIn : '0;
            counter_clr <= clr_next;
            if (writeEn && rgn == RGN_OSD)  ram_wraddress <= {page, addr[6:0]};
            if (writeEn && rgn == RGN_PAGE) page <= dataIn[PAGE_W-1:0];
            if (writeEn && rgn == RGN_CTRL) begin
                for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                    if (addr == CTRL_BASE + 8'(k)) ctrl[k*8 +: 8] <= dataIn;
                end
            end
        end
    end

endmodule

// File: tb/tb_regbank_snapshot.sv
// Self-checking bench for regbank_snapshot: behavioural address-map model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_regbank_snapshot;

    localparam int          NCTRL = 4;
    localparam int          NC    = 6;
    localparam int          PW    = 3;
    localparam logic [31:0] INIT  = 32'h4433_2211;

    logic                  clk;
    logic                  reset_n;
    logic [7:0]            addr;
    logic [7:0]            dataIn;
    logic                  writeEn;
    logic                  readEn;
    logic [7:0]            dataOut;
    logic [PW+6:0]         ram_wraddress;
    logic [7:0]            ram_dataIn;
    logic                  ram_wren;
    logic [NCTRL*8-1:0]    ctrl;
    logic [7:0]            pulse;
    logic [NC*32-1:0]      counters;
    logic [NC-1:0]         counter_clr;

    logic [31:0]           cnt [NC];

    int n_assert = 0;
    int n_fail   = 0;

    regbank_snapshot #(
        .NUM_CTRL     (NCTRL),
        .NUM_COUNTERS (NC),
        .PAGE_W       (PW),
        .CTRL_INIT    (INIT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .addr          (addr),
        .dataIn        (dataIn),
        .writeEn       (writeEn),
        .readEn        (readEn),
        .dataOut       (dataOut),
        .ram_wraddress (ram_wraddress),
        .ram_dataIn    (ram_dataIn),
        .ram_wren      (ram_wren),
        .ctrl          (ctrl),
        .pulse         (pulse),
        .counters      (counters),
        .counter_clr   (counter_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NC; k++) counters[k*32 +: 32] = cnt[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_page;
    int          m_ctrl [NCTRL];
    logic [31:0] m_sh;
    int          m_sh_idx;
    bit          m_sh_vld;

    logic [7:0]         e_dout;
    logic               e_wren;
    logic [PW+6:0]      e_wraddr;
    logic [7:0]         e_wdata;
    logic [7:0]         e_pulse;
    logic [NC-1:0]      e_clr;
    logic [NCTRL*8-1:0] e_ctrl;

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int ai, k, b;
        logic [31:0] w;
        ai = int'(a);
        if (ai == 'h80) return 8'(m_page);
        if (ai >= 'h81 && ai <= 'h80 + NCTRL) return 8'(m_ctrl[ai - 'h81]);
        if (ai >= 'hA0 && ai < 'hA0 + 4 * NC) begin
            k = (ai - 'hA0) / 4;
            b = (ai - 'hA0) % 4;
            w = cnt[k];
`ifdef REGBANK_SNAPSHOT_EN
            if (b != 0 && m_sh_vld && m_sh_idx == k) w = m_sh;
`endif
            return 8'(w >> (8 * (3 - b)));
        end
        if (ai == 'hF2) return 8'(((NC - 1) % 16) * 16 + (NCTRL % 16));
        return 8'h00;
    endfunction

    initial begin
        m_page = 0; m_sh = '0; m_sh_idx = 0; m_sh_vld = 0;
        e_wraddr = '0;
        for (int k = 0; k < NCTRL; k++) m_ctrl[k] = int'(INIT >> (8 * k)) & 'hFF;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                e_dout = 8'h00; e_wren = 1'b0; e_wraddr = '0; e_pulse = 8'h00; e_clr = '0;
                m_page = 0; m_sh = '0; m_sh_idx = 0; m_sh_vld = 0;
                for (int k = 0; k < NCTRL; k++) m_ctrl[k] = int'(INIT >> (8 * k)) & 'hFF;
            end else begin
                e_dout  = m_read(addr);
                e_wren  = writeEn && (addr < 8'h80);
                e_wdata = dataIn;
                if (e_wren) e_wraddr = (PW+7)'(m_page * 128 + int'(addr));
                e_pulse = (writeEn && addr == 8'hF0) ? dataIn : 8'h00;
                e_clr   = '0;
                if (writeEn && addr == 8'hF1) begin
                    if (dataIn == 8'hFF) e_clr = NC'((1 << NC) - 1);
                    else if (int'(dataIn) < NC) e_clr = NC'(1 << int'(dataIn));
                end
                if (writeEn && addr == 8'h80) m_page = int'(dataIn) % (1 << PW);
                if (writeEn && int'(addr) >= 'h81 && int'(addr) <= 'h80 + NCTRL)
                    m_ctrl[int'(addr) - 'h81] = int'(dataIn);
`ifdef REGBANK_SNAPSHOT_EN
                if (readEn && int'(addr) >= 'hA0 && int'(addr) < 'hA0 + 4 * NC
                    && (int'(addr) - 'hA0) % 4 == 0) begin
                    m_sh_idx = (int'(addr) - 'hA0) / 4;
                    m_sh     = cnt[m_sh_idx];
                    m_sh_vld = 1;
                end
`endif
            end
            for (int k = 0; k < NCTRL; k++) e_ctrl[k*8 +: 8] = 8'(m_ctrl[k]);
            #1;
            chk("dataOut",       32'(dataOut),       32'(e_dout));
            chk("ram_wren",      32'(ram_wren),      32'(e_wren));
            chk("ram_wraddress", 32'(ram_wraddress), 32'(e_wraddr));
            chk("pulse",         32'(pulse),         32'(e_pulse));
            chk("counter_clr",   32'(counter_clr),   32'(e_clr));
            chk("ctrl",          32'(ctrl),          32'(e_ctrl));
            if (e_wren) chk("ram_dataIn", 32'(ram_dataIn), 32'(e_wdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic we, input logic re);
        @(negedge clk);
        addr = a; dataIn = d; writeEn = we; readEn = re;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 8'($urandom_range(0, 127));
            1:       return 8'h80;
            2:       return 8'($urandom_range('h81, 'h85));
            3, 4:    return 8'($urandom_range('hA0, 'hB9));
            5:       return 8'hF0;
            6:       return 8'hF1;
            7:       return 8'hF2;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic mutate_counters();
        for (int k = 0; k < NC; k++) begin
            case ($urandom_range(0, 3))
                0:       cnt[k] = cnt[k] + 32'd1;
                1:       cnt[k] = $urandom;
                default: ;
            endcase
        end
    endtask

    logic [7:0] exp_live;

    initial begin
        reset_n = 1'b0; addr = 8'h00; dataIn = 8'h00; writeEn = 1'b0; readEn = 1'b0;
        for (int k = 0; k < NC; k++) cnt[k] = 32'h1000_0000 * 32'(k) + 32'h0012_3456;
        repeat (3) @(negedge clk);
        chk("reset_dataOut", 32'(dataOut),  32'h0);
        chk("reset_ctrl",    32'(ctrl),     INIT);
        chk("reset_wren",    32'(ram_wren), 32'h0);
        chk("reset_pulse",   32'(pulse),    32'h0);
        reset_n = 1'b1;

        drive(8'hF2, 8'h00, 1'b0, 1'b0); after_edge();
        chk("info_reg", 32'(dataOut), 32'h54);

        // OSD write through page offset
        drive(8'h80, 8'h05, 1'b1, 1'b0);
        drive(8'h12, 8'h3C, 1'b1, 1'b0); after_edge();
        chk("osd_wren",  32'(ram_wren),      32'h1);
        chk("osd_waddr", 32'(ram_wraddress), 32'h292);
        chk("osd_wdata", 32'(ram_dataIn),    32'h3C);
        drive(8'h80, 8'h00, 1'b0, 1'b0); after_edge();
        chk("osd_wren_single", 32'(ram_wren), 32'h0);
        chk("page_read",       32'(dataOut),  32'h05);

        // Back-to-back command pulses
        drive(8'hF0, 8'h81, 1'b1, 1'b0); after_edge();
        chk("pulse_1", 32'(pulse), 32'h81);
        drive(8'hF0, 8'h81, 1'b1, 1'b0); after_edge();
        chk("pulse_2", 32'(pulse), 32'h81);
        drive(8'hF0, 8'h00, 1'b0, 1'b0); after_edge();
        chk("pulse_end", 32'(pulse),   32'h00);
        chk("pulse_read", 32'(dataOut), 32'h00);

        // Counter clears
        drive(8'hF1, 8'hFF, 1'b1, 1'b0); after_edge();
        chk("clr_all", 32'(counter_clr), 32'h3F);
        drive(8'hF1, 8'h09, 1'b1, 1'b0); after_edge();
        chk("clr_out_of_range", 32'(counter_clr), 32'h00);
        drive(8'hF1, 8'h02, 1'b1, 1'b0); after_edge();
        chk("clr_one", 32'(counter_clr), 32'h04);

        // Counter snapshot across a carry
        drive(8'hA4, 8'h00, 1'b0, 1'b1); cnt[1] = 32'h01FF_FFFF; after_edge();
        chk("snap_byte0", 32'(dataOut), 32'h01);
        drive(8'hA5, 8'h00, 1'b0, 1'b0); cnt[1] = 32'h0200_0000; after_edge();
`ifdef REGBANK_SNAPSHOT_EN
        chk("snap_byte1", 32'(dataOut), 32'hFF);
`else
        chk("live_byte1", 32'(dataOut), 32'h00);
`endif
        drive(8'hA6, 8'h00, 1'b0, 1'b0); after_edge();
`ifdef REGBANK_SNAPSHOT_EN
        chk("snap_byte2", 32'(dataOut), 32'hFF);
`else
        chk("live_byte2", 32'(dataOut), 32'h00);
`endif
        drive(8'hA7, 8'h00, 1'b0, 1'b0); after_edge();
`ifdef REGBANK_SNAPSHOT_EN
        chk("snap_byte3", 32'(dataOut), 32'hFF);
`else
        chk("live_byte3", 32'(dataOut), 32'h00);
`endif
        // A different counter's low byte always reads live
        drive(8'hAB, 8'h00, 1'b0, 1'b0); after_edge();
        exp_live = cnt[2][7:0];
        chk("other_counter_live", 32'(dataOut), 32'(exp_live));

        // Reset aborts pending strobes and restores control defaults
        drive(8'h81, 8'h5A, 1'b1, 1'b0); after_edge();
        chk("ctrl_write", 32'(ctrl[7:0]), 32'h5A);
        drive(8'h00, 8'h77, 1'b1, 1'b0);
        drive(8'hF0, 8'h33, 1'b1, 1'b0); reset_n = 1'b0; after_edge();
        chk("rst_ctrl0",   32'(ctrl[7:0]), 32'h11);
        chk("rst_dataOut", 32'(dataOut),   32'h00);
        chk("rst_wren",    32'(ram_wren),  32'h0);
        chk("rst_pulse",   32'(pulse),     32'h00);
        drive(8'hF2, 8'h00, 1'b0, 1'b0); reset_n = 1'b1; after_edge();
        chk("post_rst_wren",  32'(ram_wren), 32'h0);
        chk("post_rst_pulse", 32'(pulse),    32'h00);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] a, d;
            a = rand_addr();
            d = (a == 8'hF1 && $urandom_range(0, 2) == 0) ? 8'hFF :
                (a == 8'hF1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            drive(a, d, 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 3));
            reset_n = ($urandom_range(0, 63) != 0);
            mutate_counters();
        end

        // Snapshot-focused sequences: byte 0 consumed, then random byte reads
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, NC - 1);
            drive(8'('hA0 + 4 * k), 8'h00, 1'b0, 1'b1);
            mutate_counters();
            repeat (3) begin
                drive(8'('hA0 + 4 * $urandom_range(0, NC - 1) + $urandom_range(1, 3)),
                      8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                mutate_counters();
            end
        end

        drive(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
